// File: rtl/timer_multi_if.sv
// Configuration and status bundle for the multi-channel timer.
// Channel i occupies slice i of every packed vector.
interface timer_multi_if #(
  parameter int CH    = 2,
  parameter int CNT_W = 16,
  parameter int PSC_W = 4
);
  logic [CH-1:0]       start;
  logic [CH-1:0]       irq_en;
  logic [CH-1:0]       irq_clr;
  logic [2*CH-1:0]     mode;
  logic [PSC_W*CH-1:0] psc;
  logic [CNT_W*CH-1:0] load;
  logic [CNT_W*CH-1:0] cmp;
  logic [CNT_W*CH-1:0] tim_cnt;
  logic [CH-1:0]       irq_pend;
  logic [CH-1:0]       pwm_out;
  logic                tim_irq;

  modport master (
    output start, irq_en, irq_clr,
    output mode, psc, load, cmp,
    input  tim_cnt, irq_pend,
    input  pwm_out, tim_irq
  );

  modport slave (
    input  start, irq_en, irq_clr,
    input  mode, psc, load, cmp,
    output tim_cnt, irq_pend,
    output pwm_out, tim_irq
  );
endinterface

// File: rtl/timer_multi.sv
// CH independent prescaled timers: one-shot, periodic down,
// up-count with PWM compare; sticky per-channel pending bits.
module timer_multi #(
  parameter int CH    = 2,
  parameter int CNT_W = 16,
  parameter int PSC_W = 4
) (
  input  logic          CLK,
  input  logic          rst_n,
  timer_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    M_STOP = 2'b00,
    M_ONE  = 2'b01,
    M_PER  = 2'b10,
    M_UP   = 2'b11
  } mode_e;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PSC_W-1:0] psc_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam psc_t PSC_ONE = psc_t'(1);

  cnt_t cnt_q [CH];
  cnt_t cnt_d [CH];
  psc_t pre_q [CH];
  psc_t pre_d [CH];

  logic [CH-1:0] start_q;
  logic [CH-1:0] done_q, done_d;
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] pwm_q, pwm_d;
  logic [CH-1:0] evt;

  logic [CNT_W*CH-1:0] cnt_flat;

  mode_e m;
  cnt_t  ld;
  logic  tick;

  always_comb begin
    m        = M_STOP;
    ld       = '0;
    tick     = 1'b0;
    evt      = '0;
    done_d   = done_q;
    pwm_d    = '0;
    pend_d   = pend_q;
    cnt_flat = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      pre_d[i] = pre_q[i];
      m    = mode_e'(bus.mode[2*i +: 2]);
      ld   = bus.load[CNT_W*i +: CNT_W];
      tick = (pre_q[i] == bus.psc[PSC_W*i +: PSC_W]);
      pwm_d[i] = (m == M_UP) &&
                 (cnt_q[i] < bus.cmp[CNT_W*i +: CNT_W]);
      if (bus.start[i] && !start_q[i]) begin
        pre_d[i]  = '0;
        done_d[i] = 1'b0;
        unique case (m)
          M_ONE, M_PER: cnt_d[i] = ld;
          M_UP:         cnt_d[i] = '0;
          default:      cnt_d[i] = cnt_q[i];
        endcase
      end else if (!bus.start[i]) begin
        pre_d[i] = '0;
      end else if (m != M_STOP && !done_q[i]) begin
        pre_d[i] = tick ? '0 : pre_q[i] + PSC_ONE;
        if (tick) begin
          unique case (m)
            M_ONE: begin
              if (cnt_q[i] == '0) begin
                evt[i]    = 1'b1;
                done_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
              end
            end
            M_PER: begin
              if (cnt_q[i] == '0) begin
                evt[i]   = 1'b1;
                cnt_d[i] = ld;
              end else begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
              end
            end
            M_UP: begin
              // above a lowered top the count wraps via all-ones
              if (cnt_q[i] == ld) begin
                evt[i]   = 1'b1;
                cnt_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
              end
            end
            default: cnt_d[i] = cnt_q[i];
          endcase
        end
      end
      if (evt[i] && bus.irq_en[i]) begin
        pend_d[i] = 1'b1;
      end else if (bus.irq_clr[i]) begin
        pend_d[i] = 1'b0;
      end
      cnt_flat[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
        pre_q[i] <= '0;
      end
      start_q <= '0;
      done_q  <= '0;
      pend_q  <= '0;
      pwm_q   <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        pre_q[i] <= pre_d[i];
      end
      start_q <= bus.start;
      done_q  <= done_d;
      pend_q  <= pend_d;
      pwm_q   <= pwm_d;
    end
  end

  assign bus.tim_cnt  = cnt_flat;
  assign bus.irq_pend = pend_q;
  assign bus.pwm_out  = pwm_q;
  assign bus.tim_irq  = |pend_q;

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised multi-channel successor to the single 16-bit timer in the Cortex-M0 peripheral set.
- CH independent channels, each with a CNT_W-bit counter, its own (psc+1) prescaler and four modes: stop, one-shot down, periodic auto-reload down, and free-running up with compare/PWM output.
- Per-channel sticky interrupt pending bits with clear; a single ORed tim_irq line goes to the NVIC.

Parameters:
- CH, 2, number of channels (1..8).
- CNT_W, 16, counter/load/compare width.
- PSC_W, 4, prescaler field width; tick period is psc+1 clocks.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  CH  per-channel run enable (level); its rising edge (re)arms the channel.
- irq_en  in  CH  per-channel interrupt enable.
- irq_clr  in  CH  per-channel pending clear (1-cycle pulse).
- mode  in  2*CH  channel i uses bits [2i+1:2i]; 00 stop, 01 one-shot down, 10 periodic down, 11 up/PWM.
- psc  in  PSC_W*CH  per-channel prescaler value.
- load  in  CNT_W*CH  reload value (down modes) or period top (up mode).
- cmp  in  CNT_W*CH  PWM compare value (mode 11 only).
- tim_cnt  out  CNT_W*CH  current counter values.
- irq_pend  out  CH  sticky pending bits.
- pwm_out  out  CH  registered PWM outputs.
- tim_irq  out  1  OR of irq_pend.

Behaviour:
- Reset: tim_cnt=0, prescaler=0, start_d=0, done=0, irq_pend=0, pwm_out=0, tim_irq=0.
- Arm: on the edge where start=1 and start_d=0:
  - cnt<=load in modes 01/10; cnt<=0 in mode 11.
  - prescaler<=0, done<=0.
  - No event is generated on the arm edge.
- Prescaler: counts 0..psc while start=1, mode!=00 and done=0. tick=1 on the cycle prescaler==psc, then it wraps to 0. psc=0 gives a tick every cycle.
- start=0: counter holds its value, prescaler is forced to 0, no events. Re-asserting start re-arms; resume-without-reload is not supported.
- Mode 00: counter and prescaler hold; pwm_out=0.
- Mode 01, on tick:
  - if cnt!=0, cnt<=cnt-1;
  - if cnt==0, event, done<=1, cnt stays 0, and counting stops until the next arm.
- Mode 10, on tick:
  - if cnt!=0, cnt<=cnt-1;
  - if cnt==0, event and cnt<=load.
  - Period is (load+1)*(psc+1) clocks. load=0 gives an event every tick.
  - load changes take effect at the next reload.
- Mode 11, on tick:
  - if cnt==load, event and cnt<=0;
  - else cnt<=cnt+1.
  - If cnt>load (load lowered mid-run), the counter counts up to all-ones and wraps to 0; the event fires only on cnt==load.
- PWM (mode 11 only): pwm_out<=(cnt<cmp), registered, one cycle behind tim_cnt.
  - cmp=0 gives constant 0; cmp>load gives constant 1.
  - pwm_out=0 in all other modes.
- Event: irq_pend[i]<=1 if irq_en[i]=1.
  - Events with irq_en=0 are dropped; they are not latched for later.
  - irq_clr[i] clears the bit. If an event and irq_clr occur in the same cycle, set wins.
- tim_irq: combinational OR of irq_pend; no extra latency.
- Mode change mid-run takes effect at the next tick; the counter is not reloaded.
- Arithmetic is CNT_W-bit unsigned; all wrap is modulo 2^CNT_W. Channels are fully independent with no shared state.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously).

Test Plan:
1. CH=2, ch0 mode=10, load=4, psc=2, irq_en=1, start 0->1 -> tim_cnt0 4,3,2,1,0,4, changing every 3 clocks. irq_pend[0] sets 15 clocks after arm, then every 15 clocks. tim_irq follows irq_pend[0].
2. ch1 mode=01, load=3, psc=0 -> tim_cnt1 3,2,1,0 then holds 0. Exactly one event 4 clocks after arm. Toggling start 0->1 reloads 3 and gives one more event.
3. ch0 mode=11, load=9, cmp=3, psc=0 -> tim_cnt0 0..9 wraps. pwm_out[0] high for 3 of every 10 clocks, lagging the count by 1. Repeat with cmp=0 -> pwm_out stays 0; cmp=12 -> pwm_out stays 1.
4. Pending handling:
   - Event with irq_en=0 -> irq_pend stays 0.
   - irq_clr asserted in the same cycle as an event -> irq_pend=1.
   - irq_clr alone -> irq_pend=0 on the next cycle.
   - Both channels pending, clear ch0 only -> tim_irq stays 1.
5. mode=10, load=1000, psc=15; drop start at cnt=500, then assert rst_n=0 mid-count -> counter holds at 500 while start=0. On reset, all outputs go to 0 asynchronously, without waiting for a clock edge.
6. CNT_W=8, mode=11, load=255, psc=0 -> count wraps 255->0 with an event. Lowering load to 10 while cnt=50 -> count runs to 255, wraps, and subsequent events occur at cnt==10.
